// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory access controller: FSM state
// encodings, the default bus timeout, flag/strobe constants and a helper
// that extracts the word address from a byte address.
package dmem_ctrl_pkg;

   typedef enum logic [1:0] {
      IdleSt = 2'd0,
      BusySt = 2'd1,
      DoneSt = 2'd2
   } state_t;

   localparam int DefTimeout = 255;

   localparam logic SetFlag    = 1'b1;
   localparam logic ClearFlag  = 1'b0;
   localparam logic Valid      = 1'b1;
   localparam logic Invalid    = 1'b0;
   localparam logic RamWrite   = 1'b1;
   localparam logic RamUnWrite = 1'b0;

   localparam logic [31:0] Zero = 32'h0000_0000;

   // Word address of a byte address; the link granule is one 32-bit word.
   function automatic logic [29:0] word_of(input logic [31:0] byte_addr);
      return byte_addr[31:2];
   endfunction

endpackage

// File: rtl/dmem_ctrl_llbit.sv
// LL/SC link register: holds the link bit and the linked word address.
// Pipeline-driven updates happen only when MEM is not stalled; a snoop hit
// from another master clears the link on any edge.
module llbit_reg
   import dmem_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        upd,
   input  logic        excpt,
   input  logic        wbit,
   input  logic        wLLbit,
   input  logic [31:0] memAddr,
   input  logic        stHit,
   input  logic [31:0] stAddr,
   input  logic        snoop_valid,
   input  logic [31:0] snoop_addr,
   output logic        rLLbit
);

   logic [29:0] llAddr;
   logic        snoopHit;
   logic        storeHit;

   // NOTE: both compares use the link address held before this edge, so a
   // snoop arriving together with a new LL tests the old link, and the new
   // link (set below) takes precedence because it starts after the snoop.
   assign snoopHit = snoop_valid && (word_of(snoop_addr) == llAddr);
   assign storeHit = stHit && (word_of(stAddr) == llAddr);

   // Link bit and address, highest-priority cause first.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rLLbit <= ClearFlag;
         llAddr <= '0;
      end else if (upd && excpt) begin
         rLLbit <= ClearFlag;
      end else if (upd && wbit) begin
         rLLbit <= wLLbit;
         if (wLLbit) begin
            llAddr <= word_of(memAddr);
         end
      end else if (snoopHit) begin
         rLLbit <= ClearFlag;
      end else if (upd && storeHit) begin
         rLLbit <= ClearFlag;
      end
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory access controller below the MEM stage. Each MEM access runs as
// a single outstanding req/ack transaction on the data bus; the pipeline is
// stalled until the access reaches DONE. Misaligned accesses skip the bus and
// flag addr_err; accesses with no ack within TIMEOUT busy cycles flag bus_err.
module dmem_ctrl
   import dmem_ctrl_pkg::*;
#(
   parameter int TIMEOUT = DefTimeout
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        memCe,
   input  logic        memWr,
   input  logic [31:0] memAddr,
   input  logic [31:0] wtData,
   input  logic        wbit,
   input  logic        wLLbit,
   input  logic        excpt,
   input  logic        snoop_valid,
   input  logic [31:0] snoop_addr,
   output logic [31:0] rdData,
   output logic        rLLbit,
   output logic        stall,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   output logic        addr_err,
   output logic        bus_err
);

   localparam int              CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

   state_t          state;
   logic [CntW-1:0] cnt;
   logic            stDone;   // the access now in DONE was an acked store

   // The instruction leaves MEM on the DONE edge, so DONE releases the stall.
   assign stall = memCe && (state != DoneSt);

   // Access FSM with registered bus strobes, load data and error pulses.
   // NOTE: all state here is written with non-blocking assignments so every
   // register samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IdleSt;
         cnt       <= '0;
         stDone    <= ClearFlag;
         rdData    <= Zero;
         bus_req   <= Invalid;
         bus_we    <= RamUnWrite;
         bus_addr  <= Zero;
         bus_wdata <= Zero;
         addr_err  <= Invalid;
         bus_err   <= Invalid;
      end else begin
         case (state)
            IdleSt: begin
               if (memCe) begin
                  if (memAddr[1:0] == 2'b00) begin
                     state     <= BusySt;
                     cnt       <= '0;
                     bus_req   <= Valid;
                     bus_we    <= memWr;
                     bus_addr  <= memAddr;
                     bus_wdata <= wtData;
                  end else begin
                     state    <= DoneSt;
                     addr_err <= Valid;
                     rdData   <= Zero;
                  end
               end
            end
            BusySt: begin
               if (bus_ack) begin
                  state   <= DoneSt;
                  bus_req <= Invalid;
                  stDone  <= (bus_we == RamWrite);
                  if (bus_we == RamUnWrite) begin
                     rdData <= bus_rdata;
                  end
               end else if (cnt == CntLast) begin
                  state   <= DoneSt;
                  bus_req <= Invalid;
                  bus_err <= Valid;
                  rdData  <= Zero;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DoneSt: begin
               state    <= IdleSt;
               stDone   <= ClearFlag;
               addr_err <= Invalid;
               bus_err  <= Invalid;
            end
            default: begin
               state <= IdleSt;
            end
         endcase
      end
   end

   llbit_reg u_llbit (
      .clk         (clk),
      .rst         (rst),
      .upd         (!stall),
      .excpt       (excpt),
      .wbit        (wbit),
      .wLLbit      (wLLbit),
      .memAddr     (memAddr),
      .stHit       ((state == DoneSt) && stDone),
      .stAddr      (bus_addr),
      .snoop_valid (snoop_valid),
      .snoop_addr  (snoop_addr),
      .rLLbit      (rLLbit)
   );

endmodule
